btb_update_queue: RTL and testbench

Buffers resolved branch outcomes from the branch execution ports and drives the BTB's synchronous update port, one write per cycle. It sits between the branch units and the BTB write interface. It filters out outcomes the BTB already predicts correctly, so only taken branches that missed, or hit with the wrong target, consume BTB write bandwidth. There is no backpressure toward the branch units. The BTB is a hint structure, so overflow drops updates and counts them.

---
 rtl/uarch_pkg.sv | 21 ++
 rtl/btb_update_queue.sv | 146 ++++++++++++++
 tb/tb_btb_update_queue.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the BTB update path: branch-type
// encodings, the queued update record and the default queue depth.
package uarch_pkg;

    localparam int CPU_ADDR_BITS = 32;
    localparam int BTB_UPD_DEPTH = 4;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JUMP = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } br_type_e;

    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0] pc;
        logic [CPU_ADDR_BITS-1:0] targ;
        br_type_e                 btype;
    } btb_upd_t;

endpackage

// File: rtl/btb_update_queue.sv
// Filters resolved branches down to BTB misses/wrong targets and drains them one per cycle.
// Optional BTB_UPD_COALESCE_EN merges a new outcome into a pending entry with the same PC.
module btb_update_queue
    import uarch_pkg::*;
#(
    parameter int DEPTH     = BTB_UPD_DEPTH,
    parameter int NUM_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_PORTS-1:0]               res_val,
    input  logic [CPU_ADDR_BITS*NUM_PORTS-1:0] res_pc,
    input  logic [CPU_ADDR_BITS*NUM_PORTS-1:0] res_targ,
    input  logic [2*NUM_PORTS-1:0]             res_type,
    input  logic [NUM_PORTS-1:0]               res_taken,
    input  logic [NUM_PORTS-1:0]               res_pred_hit,
    input  logic [CPU_ADDR_BITS*NUM_PORTS-1:0] res_pred_targ,
    input  logic                               flush,
    output logic                               update_val,
    output logic [CPU_ADDR_BITS-1:0]           update_pc,
    output logic [CPU_ADDR_BITS-1:0]           update_targ,
    output logic [1:0]                         update_type,
    output logic                               update_taken,
    output logic [15:0]                        drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int W  = CPU_ADDR_BITS;

    btb_upd_t          entries_r [DEPTH];
    btb_upd_t          entries_s [DEPTH];
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     count_s;
    logic [15:0]       drop_cnt_r;
    logic [15:0]       drop_cnt_s;
    logic [NUM_PORTS-1:0] qual_s;
    logic              deq_s;

    assign deq_s = (count_r != '0);

    // Only taken branches the BTB missed or mispredicted the target of are worth writing
    always_comb begin
        qual_s = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            qual_s[p] = res_val[p] & res_taken[p] &
                        (~res_pred_hit[p] | (res_pred_targ[p*W +: W] != res_targ[p*W +: W]));
        end
    end

    // Next queue state: dequeue head, then place qualifying ports oldest-first
    always_comb begin
        btb_upd_t      ent_v;
        logic [CW-1:0] cnt_v;
        logic [16:0]   sum_v;
        logic          hit_v;
        entries_s = entries_r;
        cnt_v     = count_r;
        sum_v     = {1'b0, drop_cnt_r};
        ent_v     = '0;
        hit_v     = 1'b0;
        if (deq_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entries_s[i] = entries_r[i+1];
            end
            entries_s[DEPTH-1] = '0;
            cnt_v = count_r - CW'(1);
        end else begin
            cnt_v = count_r;
        end
        if (flush) begin
            cnt_v = '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                ent_v.pc    = res_pc[p*W +: W];
                ent_v.targ  = res_targ[p*W +: W];
                ent_v.btype = br_type_e'(res_type[2*p +: 2]);
                hit_v       = 1'b0;
                if (qual_s[p]) begin
`ifdef BTB_UPD_COALESCE_EN
                    // The dequeued head has already shifted out, so it can never match here
                    for (int i = 0; i < DEPTH; i++) begin
                        if (!hit_v && (i < int'(cnt_v)) && (entries_s[i].pc == ent_v.pc)) begin
                            entries_s[i].targ  = ent_v.targ;
                            entries_s[i].btype = ent_v.btype;
                            hit_v = 1'b1;
                        end else begin
                            hit_v = hit_v;
                        end
                    end
`endif
                    if (hit_v) begin
                        cnt_v = cnt_v;
                    end else if (cnt_v < CW'(DEPTH)) begin
                        entries_s[cnt_v[AW-1:0]] = ent_v;
                        cnt_v = cnt_v + CW'(1);
                    end else begin
                        sum_v = sum_v + 17'd1;
                    end
                end else begin
                    cnt_v = cnt_v;
                end
            end
        end
        count_s = cnt_v;
        if (sum_v > 17'h0FFFF) begin
            drop_cnt_s = 16'hFFFF;
        end else begin
            drop_cnt_s = sum_v[15:0];
        end
    end

    // Queue storage, occupancy and drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= '0;
            end
            count_r    <= '0;
            drop_cnt_r <= 16'h0000;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= entries_s[i];
            end
            count_r    <= count_s;
            drop_cnt_r <= drop_cnt_s;
        end
    end

    // BTB write port presents the head directly from storage
    always_comb begin
        update_val = deq_s;
        if (deq_s) begin
            update_pc   = entries_r[0].pc;
            update_targ = entries_r[0].targ;
            update_type = entries_r[0].btype;
        end else begin
            update_pc   = '0;
            update_targ = '0;
            update_type = 2'b00;
        end
        update_taken = deq_s;
        drop_cnt     = drop_cnt_r;
    end

endmodule

// File: tb/tb_btb_update_queue.sv
// Self-checking bench for btb_update_queue against a queue-based reference model.
// Build with BTB_UPD_COALESCE_EN defined to check the coalescing variant.
module tb_btb_update_queue;
    import uarch_pkg::*;

    localparam int DEPTH = 4;
    localparam int NP    = 2;
    localparam int W     = CPU_ADDR_BITS;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NP-1:0]      res_val;
    logic [W*NP-1:0]    res_pc;
    logic [W*NP-1:0]    res_targ;
    logic [2*NP-1:0]    res_type;
    logic [NP-1:0]      res_taken;
    logic [NP-1:0]      res_pred_hit;
    logic [W*NP-1:0]    res_pred_targ;
    logic               flush;
    logic               update_val;
    logic [W-1:0]       update_pc;
    logic [W-1:0]       update_targ;
    logic [1:0]         update_type;
    logic               update_taken;
    logic [15:0]        drop_cnt;

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] targ;
        logic [1:0]   bt;
    } ment_t;

    ment_t       mq[$];
    int unsigned mdrop;
    int          checks = 0;
    int          fails  = 0;
    int          pc40_writes;

    always #5 clk = ~clk;

    btb_update_queue #(.DEPTH(DEPTH), .NUM_PORTS(NP)) dut (
        .clk(clk), .rst_n(rst_n), .res_val(res_val), .res_pc(res_pc), .res_targ(res_targ),
        .res_type(res_type), .res_taken(res_taken), .res_pred_hit(res_pred_hit),
        .res_pred_targ(res_pred_targ), .flush(flush), .update_val(update_val),
        .update_pc(update_pc), .update_targ(update_targ), .update_type(update_type),
        .update_taken(update_taken), .drop_cnt(drop_cnt)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic          ev;
        logic [W-1:0]  epc;
        logic [W-1:0]  etg;
        logic [1:0]    ety;
        ev  = (mq.size() != 0);
        epc = ev ? mq[0].pc : '0;
        etg = ev ? mq[0].targ : '0;
        ety = ev ? mq[0].bt : 2'b00;
        chk("update_val", W'(update_val), W'(ev));
        chk("update_pc", update_pc, epc);
        chk("update_targ", update_targ, etg);
        chk("update_type", W'(update_type), W'(ety));
        chk("update_taken", W'(update_taken), W'(ev));
        chk("drop_cnt", W'(drop_cnt), W'(mdrop));
    endtask

    function automatic bit port_qualifies(input int p);
        return res_val[p] && res_taken[p] &&
               (!res_pred_hit[p] || (res_pred_targ[p*W +: W] != res_targ[p*W +: W]));
    endfunction

    // Reference behaviour at a clock edge, from the queue's rules
    task automatic model_edge();
        bit    found;
        ment_t e;
        if (!rst_n) begin
            mq.delete();
            mdrop = 0;
        end else begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (flush) begin
                mq.delete();
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (port_qualifies(p)) begin
                        e.pc   = res_pc[p*W +: W];
                        e.targ = res_targ[p*W +: W];
                        e.bt   = res_type[2*p +: 2];
                        found  = 1'b0;
`ifdef BTB_UPD_COALESCE_EN
                        for (int i = 0; i < mq.size(); i++) begin
                            if (!found && mq[i].pc == e.pc) begin
                                mq[i].targ = e.targ;
                                mq[i].bt   = e.bt;
                                found      = 1'b1;
                            end
                        end
`endif
                        if (!found) begin
                            if (mq.size() < DEPTH) mq.push_back(e);
                            else if (mdrop < 32'hFFFF) mdrop++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        if (update_val === 1'b1 && update_pc === 32'h40) pc40_writes++;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        res_val = '0; res_pc = '0; res_targ = '0; res_type = '0;
        res_taken = '0; res_pred_hit = '0; res_pred_targ = '0; flush = 1'b0;
    endtask

    task automatic drive(input int p, input bit v, input logic [W-1:0] pc, input logic [W-1:0] targ,
                         input logic [1:0] bt, input bit tk, input bit hit, input logic [W-1:0] ptarg);
        res_val[p]          = v;
        res_pc[p*W +: W]    = pc;
        res_targ[p*W +: W]  = targ;
        res_type[2*p +: 2]  = bt;
        res_taken[p]        = tk;
        res_pred_hit[p]     = hit;
        res_pred_targ[p*W +: W] = ptarg;
    endtask

    initial begin
        logic [W-1:0] pool [4];
        logic [W-1:0] tg;
        pool[0] = 32'h40; pool[1] = 32'h44; pool[2] = 32'h100; pool[3] = 32'h2000;
        pc40_writes = 0;
        mdrop = 0;
        idle();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();

        // Correctly predicted branch produces nothing; wrong target produces one write
        drive(0, 1'b1, 32'h100, 32'h200, 2'd1, 1'b1, 1'b1, 32'h200);
        tick();
        idle();
        tick();
        chk("no_update_on_hit", W'(update_val), W'(1'b0));
        drive(0, 1'b1, 32'h100, 32'h200, 2'd1, 1'b1, 1'b1, 32'h204);
        tick();
        idle();
        chk("mispred_pc", update_pc, 32'h100);
        chk("mispred_targ", update_targ, 32'h200);
        repeat (2) tick();

        // Both ports qualify four cycles in a row, then drain
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, 32'h1000 + W'(c * 8), 32'h3000, 2'd2, 1'b1, 1'b0, 32'h0);
            drive(1, 1'b1, 32'h1004 + W'(c * 8), 32'h3004, 2'd3, 1'b1, 1'b0, 32'h0);
            tick();
        end
        idle();
        repeat (DEPTH + 1) tick();

        // Flush with three pending entries and a qualifying port 0
        for (int c = 0; c < 2; c++) begin
            drive(0, 1'b1, 32'h500 + W'(c * 8), 32'h600, 2'd0, 1'b1, 1'b0, 32'h0);
            drive(1, 1'b1, 32'h504 + W'(c * 8), 32'h604, 2'd0, 1'b1, 1'b0, 32'h0);
            tick();
        end
        idle();
        drive(0, 1'b1, 32'h700, 32'h800, 2'd1, 1'b1, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        idle();
        chk("after_flush_empty", W'(update_val), W'(1'b0));
        repeat (2) tick();

        // Same PC re-resolved while an older copy is still queued
        pc40_writes = 0;
        drive(0, 1'b1, 32'h10, 32'h11, 2'd0, 1'b1, 1'b0, 32'h0);
        drive(1, 1'b1, 32'h14, 32'h15, 2'd0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(0, 1'b1, 32'h18, 32'h19, 2'd0, 1'b1, 1'b0, 32'h0);
        drive(1, 1'b1, 32'h1c, 32'h1d, 2'd0, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        drive(0, 1'b1, 32'h40, 32'h80, 2'd1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(0, 1'b1, 32'h44, 32'h88, 2'd1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(0, 1'b1, 32'h40, 32'h90, 2'd2, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        repeat (DEPTH + 1) tick();
`ifdef BTB_UPD_COALESCE_EN
        chk("pc40_write_count", W'(pc40_writes), W'(1));
`else
        chk("pc40_write_count", W'(pc40_writes), W'(2));
`endif

        // Asynchronous reset while two entries are pending
        drive(0, 1'b1, 32'h900, 32'h901, 2'd0, 1'b1, 1'b0, 32'h0);
        drive(1, 1'b1, 32'h904, 32'h905, 2'd0, 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        chk("pre_reset_val", W'(update_val), W'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_val", W'(update_val), W'(1'b0));
        chk("async_reset_pc", update_pc, 32'h0);
        mq.delete();
        mdrop = 0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Randomized traffic with a small PC pool to provoke duplicates and overflow
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
                tg = 32'h4000 + W'($urandom_range(0, 3) * 4);
                drive(p, 1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 3)], tg,
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) != 0),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) != 0) ? tg : 32'h4000 + W'($urandom_range(0, 3) * 4));
            end
            flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle();
        repeat (DEPTH + 1) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
